// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial half-adder subtractor.
package arith_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_using_halfadder_ha.sv
// Half-adder cell: the only arithmetic primitive of the serial subtractor.
module ha (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_subtractor_using_halfadder.sv
// Bit-serial LSB-first unsigned subtractor: a + ~b + 1 built from two half adders per bit.
module serial_subtractor_using_halfadder
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry_ff;

    logic nb0;
    logic ha1_sum, ha1_carry;
    logic s, ha2_carry;
    logic carry_next;
    logic last;
    logic accept;

    assign nb0 = ~b_sh[0];

    ha u_ha1 (
        .a     (a_sh[0]),
        .b     (nb0),
        .sum   (ha1_sum),
        .carry (ha1_carry)
    );

    ha u_ha2 (
        .a     (ha1_sum),
        .b     (carry_ff),
        .sum   (s),
        .carry (ha2_carry)
    );

    assign carry_next = ha1_carry | ha2_carry;
    assign last       = (cnt == CW'(WIDTH - 1));
    // DONE accepts a new start so operations can run back to back.
    assign accept     = start && (state != SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cnt      <= '0;
            carry_ff <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
        end else if (accept) begin
            a_sh     <= a;
            b_sh     <= b;
            carry_ff <= 1'b1;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            res      <= {s, res[WIDTH-1:1]};
            carry_ff <= carry_next;
            if (last) begin
                diff   <= {s, res[WIDTH-1:1]};
                borrow <= ~carry_next;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
